// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encodings and default parameters for the seq_tx serial burst transmitter
package seq_tx_pkg;

    localparam int DEF_PAT_W = 5;
    localparam int DEF_CNT_W = 4;
    localparam logic [4:0] DEFAULT_PATTERN = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_PARITY = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/seq_tx_shreg.sv
// rtl/seq_tx_shreg.sv - PAT_W-bit load/shift register, MSB out, zero fill
module seq_tx_shreg #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] d,
    output logic             msb
);

    logic [PAT_W-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = q[PAT_W-1];

endmodule

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - burst serial transmitter: repeated MSB-first frames with idle gaps
// Optional even-parity bit per frame: define SEQ_TX_PARITY_EN.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             a,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       cstate
);

    localparam int BW = $clog2(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gcnt;
    logic [BW-1:0]    bcnt;

    logic             accept;
    logic             bit_last;
    logic             frame_end;
    logic             last;
    logic             reload;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;
    logic [PAT_W-1:0] sh_d;

    assign accept   = start_valid && start_ready && (state == S_IDLE);
    assign bit_last = (state == S_SHIFT) && (bcnt == BW'(PAT_W - 1));
`ifdef SEQ_TX_PARITY_EN
    assign frame_end = (state == S_PARITY);
`else
    assign frame_end = bit_last;
`endif
    assign last     = (frames == CNT_W'(1));
    // back-to-back frame (no gap) or the final gap cycle both restart the shifter
    assign reload   = (frame_end && !last && (gap_q == '0)) ||
                      ((state == S_GAP) && (gcnt == CNT_W'(1)));
    assign sh_load  = accept || reload;
    assign sh_shift = (state == S_SHIFT) && !bit_last;
    // a already carries the MSB on load, so the shifter holds the remaining bits
    assign sh_d     = accept ? {pattern[PAT_W-2:0], 1'b0} : {pat_q[PAT_W-2:0], 1'b0};

    seq_tx_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (sh_d),
        .msb   (sh_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            frames      <= '0;
            gap_q       <= '0;
            gcnt        <= '0;
            bcnt        <= '0;
            a           <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            if (reload) begin
                state       <= S_SHIFT;
                a           <= pat_q[PAT_W-1];
                frame_start <= 1'b1;
                bcnt        <= '0;
                if (frame_end) begin
                    frames <= frames - CNT_W'(1);
                end
            end else if (frame_end) begin
                frames <= frames - CNT_W'(1);
                a      <= 1'b0;
                if (!last) begin
                    state <= S_GAP;
                    gcnt  <= gap_q;
                end else begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        a <= 1'b0;
                        if (accept) begin
                            state       <= S_SHIFT;
                            pat_q       <= pattern;
                            frames      <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                            gap_q       <= gap;
                            bcnt        <= '0;
                            a           <= pattern[PAT_W-1];
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                            start_ready <= 1'b0;
                        end else begin
                            start_ready <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
`ifdef SEQ_TX_PARITY_EN
                        if (bit_last) begin
                            state <= S_PARITY;
                            a     <= ^pat_q;
                        end else
`endif
                        begin
                            bcnt <= bcnt + BW'(1);
                            a    <= sh_msb;
                        end
                    end
                    S_GAP: begin
                        gcnt <= gcnt - CNT_W'(1);
                        a    <= 1'b0;
                    end
                    S_DONE: begin
                        state       <= S_IDLE;
                        a           <= 1'b0;
                        start_ready <= 1'b1;
                    end
                    default: begin
                        state       <= S_IDLE;
                        a           <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cstate = state;

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - scoreboard bench for seq_tx: queued expected stream, negedge monitor
module tb_seq_tx;
    import seq_tx_pkg::*;

    localparam int PAT_W = 5;
    localparam int CNT_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap;
    logic             a;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic [2:0]       cstate;

    int n_cmp = 0;
    int n_err = 0;
    int zcnt  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;
    logic [4:0] hist = '0;

    seq_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap         (gap),
        .a           (a),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .cstate      (cstate)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // expected {a, frame_start, done} per active cycle of one burst
    task automatic push_burst(input logic [PAT_W-1:0] pat, input int f, input int g);
        for (int fr = 0; fr < f; fr++) begin
            for (int i = PAT_W - 1; i >= 0; i--) begin
                exp_q.push_back({pat[i], (i == PAT_W - 1) ? 1'b1 : 1'b0, 1'b0});
            end
            if (PAR == 1) exp_q.push_back({^pat, 2'b00});
            if (fr < f - 1) begin
                for (int k = 0; k < g; k++) exp_q.push_back(3'b000);
            end
        end
        exp_q.push_back(3'b001);
    endtask

    task automatic run_burst(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                             input logic [CNT_W-1:0] g, input bit toggle);
        int f;
        int cyc;
        int k;
        int want;
        bit seen;
        f    = (rep == 0) ? 1 : int'(rep);
        want = f * (PAT_W + PAR) + (f - 1) * int'(g) + 1;
        push_burst(pat, f, int'(g));
        k = 0;
        @(negedge clk);
        while (!start_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(start_ready === 1'b1, "ready_before", int'(start_ready), 1);
        pattern     = pat;
        repeat_cnt  = rep;
        gap         = g;
        start_valid = 1'b1;
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!toggle) begin
                start_valid = 1'b0;
            end else begin
                pattern    = ~pattern;
                repeat_cnt = ~repeat_cnt;
                gap        = ~gap;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        start_valid = 1'b0;
        check(seen && cyc == want, "done_cycle", cyc, want);
        @(negedge clk);
        check(start_ready === 1'b1 && busy === 1'b0, "ready_after", int'(start_ready), 1);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    // monitor: every cycle the DUT is busy or signalling done consumes one expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", int'({a, frame_start, done}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({a, frame_start, done} === mon_e, "stream",
                          int'({a, frame_start, done}), int'(mon_e));
                end
            end
        end
    end

    // loopback 10010 sequence detector (overlapping) on the serial output
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                hist = {hist[3:0], a};
                if (hist == 5'b10010) zcnt++;
            end
        end
    end

    initial begin
        int z0;
        rst         = 1'b0;
        start_valid = 1'b0;
        pattern     = '0;
        repeat_cnt  = '0;
        gap         = '0;
        repeat (3) @(negedge clk);
        check({a, frame_start, busy, done, start_ready} === 5'b0, "reset_outputs",
              int'({a, frame_start, busy, done, start_ready}), 0);
        check(cstate === 3'd0, "reset_cstate", int'(cstate), 0);
        rst = 1'b1;
        @(negedge clk);
        check(start_ready === 1'b1, "ready_first_edge", int'(start_ready), 1);

        run_burst(DEFAULT_PATTERN, 4'd1, 4'd0, 1'b0);
        run_burst(DEFAULT_PATTERN, 4'd3, 4'd2, 1'b0);
        run_burst(5'b10010, 4'd2, 4'd1, 1'b0);
        run_burst(5'b10110, 4'd2, 4'd1, 1'b0);
        run_burst(5'b01101, 4'd0, 4'd3, 1'b0);
        run_burst(5'b11111, 4'd15, 4'd0, 1'b0);
        run_burst(5'b10010, 4'd2, 4'd1, 1'b1);

        // abort on the 3rd bit of frame 2
        push_burst(5'b10010, 3, 2);
        @(negedge clk);
        pattern     = 5'b10010;
        repeat_cnt  = 4'd3;
        gap         = 4'd2;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check({a, frame_start, busy, done} === 4'b0, "abort_outputs",
              int'({a, frame_start, busy, done}), 0);
        check(cstate === 3'd0, "abort_cstate", int'(cstate), 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check(done === 1'b0 && start_ready === 1'b0, "abort_quiet",
                  int'({done, start_ready}), 0);
        end
        rst = 1'b1;
        run_burst(5'b01011, 4'd2, 4'd0, 1'b0);

        z0 = zcnt;
        run_burst(DEFAULT_PATTERN, 4'd4, 4'd2, 1'b0);
        check(zcnt - z0 == 4, "detector_hits", zcnt - z0, 4);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0 && busy === 1'b0, "final_idle", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
